pwm_duty_decoder: RTL
=====================

// Module: pwm_duty_decoder
// PURPOSE
//   Receive-side companion to the motor PWM generator. Recovers the 8-bit speed
//   code from an incoming PWM waveform by counting high clocks over fixed
//   2^CNT_W-cycle windows. Tracks lock when successive windows agree. Sits on
//   the feedback/monitor path next to the motor controller, same clock domain.
// PARAMETERS
//   CNT_W          8  window = 2^CNT_W clocks; duty output width
//   SYNC_STAGES    2  synchroniser flops on pwm_in (>=2)
//   STABLE_WINDOWS 2  consecutive in-tolerance windows needed for lock
//   TOL            2  max |duty_new - duty_prev| counted as "in tolerance"
// PORTS
//   clk         in   1      system clock, rising edge
//   rst         in   1      synchronous reset, active-high
//   enable      in   1      1 = measure; 0 = idle, counters cleared
//   pwm_in      in   1      PWM waveform (asynchronous to clk)
//   duty        out  CNT_W  recovered duty code (high clocks per window, sat.)
//   duty_valid  out  1      1-cycle pulse when duty updates
//   locked      out  1      1 = last STABLE_WINDOWS windows within TOL
// BEHAVIOUR
//   Reset: duty=0, duty_valid=0, locked=0, sync chain=0, all counters=0, FSM=IDLE.
//   pwm_s = pwm_in after SYNC_STAGES flops; input-to-count latency SYNC_STAGES.
//   win_cnt (CNT_W bits) counts 0..2^CNT_W-1, wraps; starts at 0 on first enabled
//     cycle. hi_cnt (CNT_W+1 bits) += pwm_s each enabled cycle.
//   Window end = cycle with win_cnt==all-ones; that cycle's pwm_s is included.
//     meas = min(hi_cnt_final, 2^CNT_W-1) (256 high clocks -> 255).
//     Next cycle: hi_cnt restarts (0 + pwm_s of first cycle), prev <= meas.
//   diff = |meas - prev|, computed at CNT_W+1 bits, no wrap.
//   FSM (transitions on window end unless stated):
//     IDLE : enable=0. win_cnt=hi_cnt=match=0. enable=1 -> ACQ.
//     ACQ  : first window after entry only loads prev (no compare).
//            diff<=TOL -> match++; match reaching STABLE_WINDOWS -> LOCKED.
//            diff>TOL  -> match=0.
//     LOCKED: diff<=TOL -> stay; diff>TOL -> ACQ, match=0, locked falls.
//     Any state, enable=0 -> IDLE next cycle (mid-window data discarded).
//   Outputs: locked=1 only in LOCKED. In LOCKED, every window end: duty<=meas
//     and duty_valid=1 on the following cycle. The window causing ACQ->LOCKED
//     also updates duty/pulses valid. No duty_valid in IDLE/ACQ; duty holds
//     its last value there (incl. after enable drop).
//   Latency: window end -> duty/duty_valid registered 1 clk later.
//   Constant 0 or constant 1 input is legal: measures 0 / 255, locks normally.
//   rst wins over enable; rst mid-window aborts the window.
// CONFIGURATION
//   PWM_DEC_AVG_EN defined: in LOCKED, duty <= (meas + prev) >> 1, CNT_W+1
//     bit sum, truncating. Lock/tolerance logic still uses raw meas.
//   Not defined: duty <= meas (raw), no averaging logic.
// TESTING
//   1 rst=1 for 3 clks, pwm_in toggling -> duty=0, duty_valid=0, locked=0.
//   2 enable=1, 256-clk PWM with 64 high, arbitrary phase -> locked within
//     STABLE_WINDOWS+2 windows, duty=64, duty_valid once per 256 clks.
//   3 pwm_in stuck 0 -> duty=0 locked; stuck 1 -> duty=255 (saturated).
//   4 locked at 64, step to 192 -> locked=0 at next window end, duty holds 64,
//     relock with duty=192 (avg build: first locked duty per AVG rule).
//   5 enable=0 mid-window at 128 -> locked=0 next clk, no valid pulses, duty
//     stays 128; enable=1 -> window restarts at win_cnt=0, relocks at 128.
//   6 rst pulse while locked -> all outputs 0 next clk; relock after release.

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - recovers an 8-bit duty code from a PWM input using fixed 2^CNT_W-clock windows, with lock tracking.
// Define PWM_DEC_AVG_EN to report (meas + prev) / 2 while locked instead of the raw window count.
module pwm_duty_decoder #(
  parameter int CNT_W          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_WINDOWS = 2,
  parameter int TOL            = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty,
  output logic             duty_valid,
  output logic             locked
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int MATCH_W = $clog2(STABLE_WINDOWS + 1);
  localparam logic [CNT_W:0] SAT   = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0] TOL_V = (CNT_W + 1)'(TOL);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic [1:0]             state;
  logic [CNT_W-1:0]       win_cnt;
  logic [CNT_W:0]         hi_cnt;
  logic [CNT_W-1:0]       prev;
  logic [MATCH_W-1:0]     match;
  logic                   first_win;

  logic [CNT_W:0]         hi_final;
  logic [CNT_W-1:0]       meas;
  logic [CNT_W:0]         diff;
  logic                   in_tol;
  logic                   win_end;
  logic [MATCH_W-1:0]     match_inc;
  logic                   lock_hit;
  logic [CNT_W-1:0]       duty_next;

  assign pwm_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  // The window-end cycle's own sample is folded in combinationally so a full-high window reads 256 before saturation.
  always_comb begin
    hi_final  = hi_cnt + (CNT_W + 1)'(pwm_s);
    meas      = (hi_final > SAT) ? SAT[CNT_W-1:0] : hi_final[CNT_W-1:0];
    diff      = ({1'b0, meas} >= {1'b0, prev}) ? ({1'b0, meas} - {1'b0, prev})
                                               : ({1'b0, prev} - {1'b0, meas});
    in_tol    = (diff <= TOL_V);
    win_end   = enable && (win_cnt == {CNT_W{1'b1}});
    match_inc = match + MATCH_W'(1);
    lock_hit  = (int'(match_inc) >= STABLE_WINDOWS);
  end

`ifdef PWM_DEC_AVG_EN
  logic [CNT_W:0] avg_sum;
  always_comb begin
    avg_sum   = {1'b0, meas} + {1'b0, prev};
    duty_next = avg_sum[CNT_W:1];
  end
`else
  assign duty_next = meas;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      win_cnt    <= '0;
      hi_cnt     <= '0;
      prev       <= '0;
      match      <= '0;
      first_win  <= 1'b0;
      duty       <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (!enable) begin
        state     <= ST_IDLE;
        win_cnt   <= '0;
        hi_cnt    <= '0;
        match     <= '0;
        first_win <= 1'b0;
      end else begin
        win_cnt <= win_cnt + CNT_W'(1);
        hi_cnt  <= win_end ? '0 : hi_final;
        case (state)
          ST_IDLE: begin
            state     <= ST_ACQ;
            first_win <= 1'b1;
            match     <= '0;
          end
          ST_ACQ: begin
            if (win_end) begin
              prev <= meas;
              if (first_win) begin
                first_win <= 1'b0;
              end else if (in_tol) begin
                if (lock_hit) begin
                  state      <= ST_LOCKED;
                  match      <= '0;
                  duty       <= duty_next;
                  duty_valid <= 1'b1;
                end else begin
                  match <= match_inc;
                end
              end else begin
                match <= '0;
              end
            end
          end
          ST_LOCKED: begin
            if (win_end) begin
              prev <= meas;
              if (in_tol) begin
                duty       <= duty_next;
                duty_valid <= 1'b1;
              end else begin
                state     <= ST_ACQ;
                match     <= '0;
                first_win <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule
